// File: rtl/capp_pkg.sv
// Shared types and helpers for the content-addressable parallel processor.
package capp_pkg;

    // Command opcodes.
    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_SEARCH       = 3'd1,
        OP_SELECT_FIRST = 3'd2,
        OP_WRITE        = 3'd3,
        OP_READ         = 3'd4,
        OP_SET_ALL      = 3'd5,
        OP_COUNT        = 3'd6,
        OP_RESERVED     = 3'd7
    } capp_op_e;

    // How a SEARCH result combines with the existing tags.
    typedef enum logic [1:0] {
        TAG_LOAD   = 2'd0,
        TAG_AND    = 2'd1,
        TAG_OR     = 2'd2,
        TAG_ANDNOT = 2'd3
    } capp_tag_mode_e;

    // Control FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } capp_state_e;

    // Number of COUNT cycles: one per chunk, final chunk may be partial.
    function automatic int unsigned count_cycles(input int unsigned num_cells,
                                                 input int unsigned count_chunk);
        return (num_cells + count_chunk - 1) / count_chunk;
    endfunction

endpackage

// File: rtl/capp_cell.sv
// One storage word: masked compare against the comparand and per-bit write.
module capp_cell
    import capp_pkg::*;
#(
    parameter int unsigned num_bits = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [num_bits-1:0]   comparand,
    input  logic [num_bits-1:0]   mask,
    input  logic [2*num_bits-1:0] write_lines,
    output logic [num_bits-1:0]   word,
    output logic                  match_c
);

    logic [num_bits-1:0] set_bits;
    logic [num_bits-1:0] clr_bits;

    // Decode write line pairs: exactly one line of a pair forces the bit.
    always_comb begin
        set_bits = '0;
        clr_bits = '0;
        for (int unsigned i = 0; i < num_bits; i++) begin
            set_bits[i] = write_lines[2*i]   & ~write_lines[2*i+1];
            clr_bits[i] = write_lines[2*i+1] & ~write_lines[2*i];
        end
    end

    assign match_c = ((word ^ comparand) & mask) == '0;

    // Word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (write_en) begin
            word <= (word | set_bits) & ~clr_bits;
        end
    end

endmodule

// File: rtl/capp_core.sv
// Associative processor core: cell array, tag register, select/read logic and COUNT engine.
module capp_core
    import capp_pkg::*;
#(
    parameter int unsigned num_bits    = 32,
    parameter int unsigned num_cells   = 100,
    parameter int unsigned count_chunk = 16
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [1:0]                    tag_mode,
    input  logic [num_bits-1:0]           comparand,
    input  logic [num_bits-1:0]           mask,
    input  logic [2*num_bits-1:0]         write_lines,
    output logic                          rsp_valid,
    output logic                          rsp_err,
    output logic [num_bits-1:0]           read_lines,
    output logic [$clog2(num_cells+1)-1:0] match_count,
    output logic [num_cells-1:0]          tag_wires,
    output logic                          any_match
);

    localparam int unsigned cnt_cycles = count_cycles(num_cells, count_chunk);
    localparam int unsigned cnt_w      = (cnt_cycles > 1) ? $clog2(cnt_cycles) : 1;
    localparam int unsigned mc_w       = $clog2(num_cells + 1);

    capp_state_e          state, state_nxt;
    capp_op_e             op_c;
    capp_tag_mode_e       mode_c;
    logic                 accept_c;
    logic                 last_chunk_c;
    logic [cnt_w-1:0]     chunk_idx, chunk_idx_nxt;
    logic [mc_w-1:0]      acc, acc_nxt, match_count_nxt, chunk_pop_c;
    logic [num_cells-1:0] tags_nxt, match_vec_c, write_en_c;
    logic [num_bits-1:0]  read_nxt, read_or_c;
    logic [num_bits-1:0]  cell_word [num_cells];
    logic                 cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;

    assign accept_c     = cmd_valid && cmd_ready;
    assign op_c         = capp_op_e'(cmd_op);
    assign mode_c       = capp_tag_mode_e'(tag_mode);
    assign last_chunk_c = (chunk_idx == cnt_w'(cnt_cycles - 1));

    for (genvar c = 0; c < num_cells; c++) begin : g_cell
        assign write_en_c[c] = accept_c && (op_c == OP_WRITE) && tag_wires[c];

        capp_cell #(.num_bits(num_bits)) u_cell (
            .clk         (CLK),
            .rst_n       (RST_N),
            .write_en    (write_en_c[c]),
            .comparand   (comparand),
            .mask        (mask),
            .write_lines (write_lines),
            .word        (cell_word[c]),
            .match_c     (match_vec_c[c])
        );
    end

    // OR of all tagged words for READ.
    always_comb begin
        read_or_c = '0;
        for (int unsigned c = 0; c < num_cells; c++) begin
            if (tag_wires[c]) read_or_c = read_or_c | cell_word[c];
        end
    end

    // Popcount of the tag chunk selected by chunk_idx; cells past the end count as zero.
    always_comb begin
        chunk_pop_c = '0;
        for (int unsigned c = 0; c < num_cells; c++) begin
            if ((c / count_chunk) == 32'(chunk_idx)) chunk_pop_c = chunk_pop_c + mc_w'(tag_wires[c]);
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            chunk_idx   <= '0;
            acc         <= '0;
            tag_wires   <= '0;
            any_match   <= 1'b0;
            read_lines  <= '0;
            match_count <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            chunk_idx   <= chunk_idx_nxt;
            acc         <= acc_nxt;
            tag_wires   <= tags_nxt;
            any_match   <= |tags_nxt;
            read_lines  <= read_nxt;
            match_count <= match_count_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_err     <= rsp_err_nxt;
        end
    end

    // Next state: COUNT is entered on acceptance and left after the last chunk.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept_c && (op_c == OP_COUNT)) state_nxt = ST_COUNT;
            ST_COUNT: if (last_chunk_c) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next datapath and output values.
    always_comb begin
        chunk_idx_nxt   = chunk_idx;
        acc_nxt         = acc;
        tags_nxt        = tag_wires;
        read_nxt        = read_lines;
        match_count_nxt = match_count;
        cmd_ready_nxt   = (state_nxt == ST_IDLE);
        rsp_valid_nxt   = 1'b0;
        rsp_err_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    rsp_valid_nxt = (op_c != OP_COUNT);
                    case (op_c)
                        OP_SEARCH: begin
                            case (mode_c)
                                TAG_LOAD:   tags_nxt = match_vec_c;
                                TAG_AND:    tags_nxt = tag_wires & match_vec_c;
                                TAG_OR:     tags_nxt = tag_wires | match_vec_c;
                                TAG_ANDNOT: tags_nxt = tag_wires & ~match_vec_c;
                                default:    tags_nxt = tag_wires;
                            endcase
                        end
                        OP_SELECT_FIRST: tags_nxt = tag_wires & (~tag_wires + num_cells'(1));
                        OP_READ:         read_nxt = read_or_c;
                        OP_SET_ALL:      tags_nxt = '1;
                        OP_COUNT: begin
                            chunk_idx_nxt = '0;
                            acc_nxt       = '0;
                        end
                        OP_RESERVED:     rsp_err_nxt = 1'b1;
                        OP_NOP, OP_WRITE: ;
                        default: ;
                    endcase
                end
            end
            ST_COUNT: begin
                acc_nxt       = acc + chunk_pop_c;
                chunk_idx_nxt = chunk_idx + cnt_w'(1);
                if (last_chunk_c) begin
                    match_count_nxt = acc + chunk_pop_c;
                    rsp_valid_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_capp_core.sv
// Directed bench for capp_core with a cycle-level behavioural model and a per-cycle compare.
module tb_capp_core;

    localparam int NB    = 32;
    localparam int NC    = 100;
    localparam int CH    = 16;
    localparam int N_CNT = 7;   // ceil(100/16)
    localparam int MCW   = 7;   // clog2(101)

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = 3'd0;
    logic [1:0]      tag_mode = 2'd0;
    logic [NB-1:0]   comparand = '0;
    logic [NB-1:0]   mask = '0;
    logic [2*NB-1:0] write_lines = '0;
    logic            rsp_valid;
    logic            rsp_err;
    logic [NB-1:0]   read_lines;
    logic [MCW-1:0]  match_count;
    logic [NC-1:0]   tag_wires;
    logic            any_match;

    always #5 CLK = ~CLK;

    capp_core #(.num_bits(NB), .num_cells(NC), .count_chunk(CH)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .tag_mode    (tag_mode),
        .comparand   (comparand),
        .mask        (mask),
        .write_lines (write_lines),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .read_lines  (read_lines),
        .match_count (match_count),
        .tag_wires   (tag_wires),
        .any_match   (any_match)
    );

    // Behavioural model state.
    logic [NB-1:0]  m_word [NC];
    logic [NC-1:0]  m_tag;
    logic [NB-1:0]  m_read;
    logic [MCW-1:0] m_count;
    logic [MCW-1:0] m_pend;
    logic           m_rv, m_re, m_ready;
    int             m_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) m_word[c] = '0;
        m_tag   = '0;
        m_read  = '0;
        m_count = '0;
        m_pend  = '0;
        m_rv    = 1'b0;
        m_re    = 1'b0;
        m_ready = 1'b1;
        m_busy  = 0;
    endtask

    function automatic logic m_match(input int c, input logic [NB-1:0] cmp, input logic [NB-1:0] msk);
        return ((m_word[c] ^ cmp) & msk) == '0;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [NC-1:0] mv;
        logic [NC-1:0] first;
        bit            found;
        if (!RST_N) begin
            model_reset();
            return;
        end
        m_rv = 1'b0;
        m_re = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_count = m_pend;
                m_rv    = 1'b1;
                m_ready = 1'b1;
            end
        end else if (cmd_valid) begin
            m_rv = 1'b1;
            case (cmd_op)
                3'd1: begin
                    for (int c = 0; c < NC; c++) mv[c] = m_match(c, comparand, mask);
                    case (tag_mode)
                        2'd0: m_tag = mv;
                        2'd1: m_tag = m_tag & mv;
                        2'd2: m_tag = m_tag | mv;
                        default: m_tag = m_tag & ~mv;
                    endcase
                end
                3'd2: begin
                    first = '0;
                    found = 1'b0;
                    for (int c = 0; c < NC; c++) begin
                        if (!found && m_tag[c]) begin
                            first[c] = 1'b1;
                            found = 1'b1;
                        end
                    end
                    m_tag = first;
                end
                3'd3: begin
                    for (int c = 0; c < NC; c++) begin
                        if (m_tag[c]) begin
                            for (int b = 0; b < NB; b++) begin
                                if (write_lines[2*b] && !write_lines[2*b+1]) m_word[c][b] = 1'b1;
                                else if (!write_lines[2*b] && write_lines[2*b+1]) m_word[c][b] = 1'b0;
                            end
                        end
                    end
                end
                3'd4: begin
                    m_read = '0;
                    for (int c = 0; c < NC; c++) if (m_tag[c]) m_read = m_read | m_word[c];
                end
                3'd5: m_tag = '1;
                3'd6: begin
                    m_rv    = 1'b0;
                    m_busy  = N_CNT;
                    m_ready = 1'b0;
                    m_pend  = MCW'($countones(m_tag));
                end
                3'd7: m_re = 1'b1;
                default: ;
            endcase
        end
    endtask

    // Compare every observable output against the model.
    task automatic compare();
        cyc++;
        chk("cmd_ready", 128'(cmd_ready), 128'(m_ready));
        chk("rsp_valid", 128'(rsp_valid), 128'(m_rv));
        if (m_rv) chk("rsp_err", 128'(rsp_err), 128'(m_re));
        chk("tag_wires", 128'(tag_wires), 128'(m_tag));
        chk("any_match", 128'(any_match), 128'(|m_tag));
        chk("read_lines", 128'(read_lines), 128'(m_read));
        chk("match_count", 128'(match_count), 128'(m_count));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare();
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] md, input logic [NB-1:0] cmp,
                       input logic [NB-1:0] msk, input logic [2*NB-1:0] wl);
        cmd_op      = op;
        tag_mode    = md;
        comparand   = cmp;
        mask        = msk;
        write_lines = wl;
        cmd_valid   = 1'b1;
        cycle();
        cmd_valid   = 1'b0;
    endtask

    // Issue COUNT and wait for completion; optionally offer SET_ALL throughout the busy period.
    task automatic run_count(input bit hold, output int low);
        low = 0;
        cmd(3'd6, 2'd0, '0, '0, '0);
        if (!cmd_ready) low++;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            cmd_op    = 3'd5;
            cmd_valid = hold;
            cycle();
            if (!cmd_ready) low++;
        end
        cmd_valid = 1'b0;
        if (!cmd_ready) chk("count_timeout", 128'(cmd_ready), 128'(1));
    endtask

    function automatic logic [2*NB-1:0] wl_for(input logic [NB-1:0] v);
        logic [2*NB-1:0] wl;
        for (int b = 0; b < NB; b++) begin
            wl[2*b]   = v[b];
            wl[2*b+1] = ~v[b];
        end
        return wl;
    endfunction

    initial begin
        int            low;
        logic [NB-1:0] v;
        logic [127:0]  e;

        model_reset();
        repeat (2) cycle();
        chk("lit_rst_ready", 128'(cmd_ready), 128'(1));
        chk("lit_rst_tags", 128'(tag_wires), 128'(0));
        chk("lit_rst_count", 128'(match_count), 128'(0));
        RST_N = 1'b1;
        cycle();

        // Fill every word with all-ones and tag everything.
        cmd(3'd5, 2'd0, '0, '0, '0);
        cmd(3'd3, 2'd0, '0, '0, 64'h5555_5555_5555_5555);
        cmd(3'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
        chk("lit_all_tags", 128'(tag_wires), {28'd0, {NC{1'b1}}});
        run_count(1'b0, low);
        chk("lit_count_busy", 128'(low), 128'(N_CNT));
        chk("lit_count_100", 128'(match_count), 128'(100));
        chk("lit_count_rsp", 128'(rsp_valid), 128'(1));

        // Give cells 0..70 distinct values, one at a time.
        for (int i = 0; i <= 70; i++) begin
            cmd(3'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
            cmd(3'd2, 2'd0, '0, '0, '0);
            v = (i == 3) ? 32'h0000_00A5 : (i == 70) ? 32'h0000_01A5 : 32'(i);
            cmd(3'd3, 2'd0, '0, '0, wl_for(v));
        end
        cmd(3'd1, 2'd0, 32'h0000_00A5, 32'h0000_00FF, '0);
        e = (128'(1) << 3) | (128'(1) << 70);
        chk("lit_tags_3_70", 128'(tag_wires), e);
        cmd(3'd4, 2'd0, '0, '0, '0);
        chk("lit_read_or", 128'(read_lines), 128'(32'h1A5));
        run_count(1'b0, low);
        chk("lit_count_2", 128'(match_count), 128'(2));
        cmd(3'd2, 2'd0, '0, '0, '0);
        chk("lit_select_first", 128'(tag_wires), 128'(1) << 3);
        cmd(3'd4, 2'd0, '0, '0, '0);
        chk("lit_read_a5", 128'(read_lines), 128'(32'hA5));

        // Non-matching AND search clears everything.
        cmd(3'd1, 2'd1, 32'h1234_5678, 32'hFFFF_FFFF, '0);
        chk("lit_any_zero", 128'(any_match), 128'(0));
        cmd(3'd4, 2'd0, '0, '0, '0);
        chk("lit_read_zero", 128'(read_lines), 128'(0));
        run_count(1'b1, low);
        chk("lit_count_zero", 128'(match_count), 128'(0));
        chk("lit_frozen_tags", 128'(tag_wires), 128'(0));

        // Back-to-back commands, one response per cycle.
        cmd(3'd1, 2'd0, 32'h0, 32'h0000_00FF, '0);
        chk("lit_b2b_rsp0", 128'(rsp_valid), 128'(1));
        cmd(3'd1, 2'd2, 32'h0000_01A5, 32'hFFFF_FFFF, '0);
        chk("lit_b2b_rsp1", 128'(rsp_valid), 128'(1));
        cmd(3'd4, 2'd0, '0, '0, '0);
        chk("lit_b2b_rsp2", 128'(rsp_valid), 128'(1));
        chk("lit_b2b_read", 128'(read_lines), 128'(32'h1A5));
        cmd(3'd1, 2'd3, 32'h0, 32'h0000_00FF, '0);
        chk("lit_andnot", 128'(tag_wires), 128'(1) << 70);
        cmd(3'd1, 2'd0, 32'hDEAD_BEEF, 32'h0, '0);
        chk("lit_mask0_all", 128'(tag_wires), {28'd0, {NC{1'b1}}});

        // Reserved opcode.
        cmd(3'd7, 2'd0, '0, '0, '0);
        chk("lit_rsv_valid", 128'(rsp_valid), 128'(1));
        chk("lit_rsv_err", 128'(rsp_err), 128'(1));
        cycle();

        // Reset in the middle of a COUNT.
        cmd(3'd5, 2'd0, '0, '0, '0);
        cmd(3'd6, 2'd0, '0, '0, '0);
        cycle();
        cycle();
        RST_N = 1'b0;
        model_reset();
        #1;
        compare();
        chk("lit_abort_ready", 128'(cmd_ready), 128'(1));
        chk("lit_abort_rsp", 128'(rsp_valid), 128'(0));
        chk("lit_abort_count", 128'(match_count), 128'(0));
        chk("lit_abort_any", 128'(any_match), 128'(0));
        cycle();
        RST_N = 1'b1;
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/capp_core.md
# capp_core

Parametrised content-addressable parallel processor core: the next-generation successor to the current `cam` block. It holds `num_cells` words of `num_bits` bits, each with a tag bit. Adds a valid/ready command port, tag-accumulating searches, and a multi-cycle chunked match-count engine. It sits between the sequencer issuing associative operations and the datapath consuming `read_lines`/`tag_wires`.

## Interface
- `num_bits`, 32, word width (≥1)
- `num_cells`, 100, number of cells (≥2)
- `count_chunk`, 16, tags popcounted per cycle in COUNT (1..`num_cells`)

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at an edge.
- `cmd_op` in 3: operation code (see Operation).
- `tag_mode` in 2: SEARCH tag combine mode.
- `comparand` in `num_bits`: search key.
- `mask` in `num_bits`: 1 = bit participates in compare.
- `write_lines` in 2*`num_bits`: bit 2i forces word bit i to 1; bit 2i+1 forces it to 0.
- `rsp_valid` out 1: one-cycle pulse, one per accepted command.
- `rsp_err` out 1: qualified by `rsp_valid`; reserved opcode.
- `read_lines` out `num_bits`: READ result, held until next READ.
- `match_count` out clog2(`num_cells`+1): COUNT result, held until next COUNT.
- `tag_wires` out `num_cells`: current tag register.
- `any_match` out 1: OR of `tag_wires`, registered with the tags.

## Operation
- Match: cell c matches iff ((word[c] ^ comparand) & mask) == 0. Mask 0 matches all cells.
- Opcodes: 0 NOP, 1 SEARCH, 2 SELECT_FIRST, 3 WRITE, 4 READ, 5 SET_ALL, 6 COUNT, 7 reserved.
  - Reserved opcode: NOP with `rsp_err`=1.
- SEARCH `tag_mode`:
  - 0 LOAD: tag = match
  - 1 AND: tag &= match
  - 2 OR: tag |= match
  - 3 ANDNOT: tag &= ~match
- SELECT_FIRST: keep only the lowest-index set tag. With no tags set, tags stay 0.
- WRITE: applies only to tagged cells, per bit i.
  - Only 2i set: bit → 1.
  - Only 2i+1 set: bit → 0.
  - Both or neither: bit unchanged.
  - Tags are unchanged.
- READ: `read_lines` = bitwise OR of all tagged words; 0 if no tags.
- SET_ALL: all tags → 1.
- COUNT: popcount of tags, `count_chunk` tags per cycle from cell 0 upward. Final partial chunk is zero-extended.
- FSM states:
  - IDLE (`cmd_ready`=1).
  - COUNT (`cmd_ready`=0): entered on accepting COUNT; stays N = ceil(`num_cells`/`count_chunk`) cycles.
  - COUNT → IDLE after N cycles, loading `match_count` and pulsing `rsp_valid`.
  - Tags are frozen during COUNT because no command can be accepted.
- Reset values:
  - All words, tags, `read_lines`, `match_count`, `rsp_valid`, `rsp_err`, `any_match` = 0.
  - `cmd_ready`=1; FSM in IDLE.

## Timing
- Non-COUNT command accepted at edge k:
  - Words/tags updated at edge k.
  - `rsp_valid` high in the cycle after edge k.
  - `cmd_ready` stays 1, giving back-to-back throughput of one command per cycle.
- COUNT accepted at edge k:
  - `cmd_ready` low from edge k to edge k+N.
  - `match_count` valid and `rsp_valid` high in the cycle after edge k+N.
  - `cmd_ready` high again in that same cycle.
- `tag_wires`/`any_match` reflect updates in the cycle after the updating edge.
- `cmd_valid` without `cmd_ready` has no effect. Command fields are sampled only at acceptance.
- No response backpressure: the consumer must take `rsp_valid` pulses.
- `RST_N` asserted mid-COUNT aborts the count; no response is produced.
- Width: `match_count` holds `num_cells` exactly (100 → 7 bits); no overflow possible.

## Structure
- Package `capp_pkg`:
  - `capp_op_e` (3-bit opcodes).
  - `capp_tag_mode_e` (2-bit).
  - Function `count_cycles(num_cells, count_chunk)`.
- Sub-module `capp_cell`, one instance per word:
  - Storage, masked compare, per-bit write.
  - Outputs its match bit.
- Top level owns the tag register, priority select, OR-reduce read, and COUNT FSM.

## Test plan
- After reset: SET_ALL; WRITE `write_lines`=0x5555_5555_5555_5555 (all words → 0xFFFF_FFFF); SEARCH LOAD comparand=0xFFFF_FFFF mask=0xFFFF_FFFF → all 100 tags 1. COUNT → `cmd_ready` low 7 cycles, then `match_count`=100.
- Write cell 3 = 0x0000_00A5 and cell 70 = 0x0000_01A5 (SEARCH to isolate, then WRITE); SEARCH LOAD comparand=0xA5 mask=0xFF → tags {3,70}. SELECT_FIRST → only tag 3; READ → `read_lines`=0xA5.
- SEARCH AND with non-matching comparand → tags 0, `any_match`=0. READ → 0; COUNT → 0.
- Back-to-back SEARCH/OR SEARCH/READ with `cmd_valid` held high → three `rsp_valid` pulses on consecutive cycles.
- Opcode 7 → `rsp_valid`=1 with `rsp_err`=1; state unchanged.
- Assert `RST_N` at cycle 3 of COUNT → no `rsp_valid`; all outputs at reset values; `cmd_ready`=1.
